// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [7:0]         clk_ratio,
  input  logic               rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr
);
  localparam int DEPTH = 2**FIFO_AW;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_d;
  logic [7:0] r, cnt, sh;
  logic [2:0] bit_idx;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic half_hit, full_hit, push, ferr_set, pop, full, wr;
  assign half_hit = cnt == (r >> 1) - 8'd1;
  assign full_hit = cnt == r - 8'd1;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    if (enable)
      case (state)
        IDLE:      state_n = (rx_d && !rx_s) ? START : IDLE;
        START:     state_n = !half_hit ? START : (rx_s ? IDLE : DATA);
        DATA:      state_n = (full_hit && bit_idx == 3'd7) ? STOP : DATA;
        STOP:      state_n = !full_hit ? STOP : (rx_s ? IDLE : WAIT_IDLE);
        WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
        default:   state_n = IDLE;
      endcase
  end
  always_comb begin
    push     = enable && state == STOP && full_hit && rx_s;
    ferr_set = enable && state == STOP && full_hit && !rx_s;
    pop      = rd_en && rd_valid;
    full     = fifo_count == (FIFO_AW+1)'(DEPTH);
    wr       = push && (!full || pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      r          <= 8'd4;
      cnt        <= '0;
      sh         <= '0;
      bit_idx    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      if (state == IDLE) r <= clk_ratio < 8'd4 ? 8'd4 : clk_ratio;
      cnt        <= (state_n != state || full_hit) ? '0 : cnt + 8'd1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && full_hit) bit_idx <= bit_idx + 3'd1;
      if (state == DATA && full_hit) sh <= {rx_s, sh[7:1]};
      frame_err  <= ferr_set;
      overrun    <= (push && full && !pop) ? 1'b1 : (err_clr ? 1'b0 : overrun);
      if (wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      fifo_count <= fifo_count + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (!rst && wr) mem[wr_ptr] <= sh;
  assign rd_valid = fifo_count != '0;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench comparing uart_rx_fifo against a queue-based frame model
module tb_uart_rx_fifo;
  logic clk, rst, enable, rx, rd_en, err_clr;
  logic [7:0] clk_ratio, rd_data;
  logic rd_valid, frame_err, overrun;
  logic [4:0] fifo_count;
  int n_cmp = 0, n_bad = 0;
  int rr = 16;
  bit chk_on = 0;
  logic [7:0] q[$];
  bit m_ovr, m_ferr, m_push, m_ferr_req;
  logic [7:0] m_byte;
  uart_rx_fifo #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_ratio(clk_ratio), .rx(rx),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    bit full, popping;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ovr  = 0;
        m_ferr = 0;
      end else begin
        full    = q.size() == 16;
        popping = rd_en && q.size() > 0;
        if (popping) void'(q.pop_front());
        if (m_push && !(full && !popping)) q.push_back(m_byte);
        if (m_push && full && !popping) m_ovr = 1;
        else if (err_clr) m_ovr = 0;
        m_ferr = m_ferr_req;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("rd_valid", rd_valid, q.size() != 0);
      chk("fifo_count", fifo_count, q.size());
      if (q.size() != 0) chk("rd_data", rd_data, q[0]);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit stop, input int abort_k, input bit abort_rst, input bit pop_at);
    int pk = 2 + rr / 2 + 9 * rr;
    for (int k = 0; k < 10 * rr + 2; k++) begin
      @(negedge clk);
      m_push = 0;
      m_ferr_req = 0;
      if (pop_at) rd_en = 0;
      if (k == abort_k) begin
        rx = 1;
        if (abort_rst) rst = 1;
        else enable = 0;
        repeat (abort_rst ? 1 : 5) @(negedge clk);
        rst = 0;
        enable = 1;
        return;
      end
      rx = k < rr ? 1'b0 : k < 9 * rr ? b[k / rr - 1] : k < 10 * rr ? stop : 1'b1;
      if (k == pk) begin
        m_push = stop;
        m_byte = b;
        m_ferr_req = !stop;
        if (pop_at) rd_en = 1;
      end
    end
  endtask
  task automatic read_exp(input logic [7:0] e);
    @(negedge clk);
    chk("rd_lit", rd_data, e);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask
  initial begin
    logic [7:0] t1 [4];
    t1 = '{8'h01, 8'h55, 8'h99, 8'hED};
    rst = 1; enable = 1; rx = 1; rd_en = 0; err_clr = 0; clk_ratio = 8'd16;
    m_push = 0; m_ferr_req = 0; m_byte = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk_on = 1;
    idle(4);
    foreach (t1[i]) send(t1[i], 1, -1, 0, 0);
    idle(4);
    chk("t1_peak", fifo_count, 4);
    foreach (t1[i]) read_exp(t1[i]);
    chk("t1_empty", fifo_count, 0);
    send(8'hA5, 0, -1, 0, 0);
    idle(20);
    send(8'h3C, 1, -1, 0, 0);
    idle(4);
    chk("t2_count", fifo_count, 1);
    read_exp(8'h3C);
    for (int i = 0; i < 17; i++) send(8'(i), 1, -1, 0, 0);
    idle(4);
    chk("t3_count", fifo_count, 16);
    chk("t3_ovr", overrun, 1);
    for (int i = 0; i < 16; i++) read_exp(8'(i));
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("t3_clr", overrun, 0);
    @(negedge clk);
    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    idle(60);
    chk("t4_count", fifo_count, 0);
    send(8'h5A, 1, -1, 0, 0);
    idle(4);
    read_exp(8'h5A);
    clk_ratio = 8'd2;
    rr = 4;
    idle(4);
    send(8'h96, 1, -1, 0, 0);
    idle(4);
    read_exp(8'h96);
    clk_ratio = 8'd16;
    rr = 16;
    idle(4);
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1, -1, 0, 0);
    send(8'h77, 1, -1, 0, 1);
    idle(4);
    chk("t6_count", fifo_count, 16);
    chk("t6_ovr", overrun, 0);
    for (int i = 1; i < 16; i++) read_exp(8'h20 + 8'(i));
    read_exp(8'h77);
    send(8'hA5, 1, 5 * 16 + 8, 0, 0);
    idle(20);
    chk("t5_abort", fifo_count, 0);
    send(8'hC3, 1, -1, 0, 0);
    idle(4);
    read_exp(8'hC3);
    send(8'h11, 1, -1, 0, 0);
    send(8'h22, 1, 3 * 16, 1, 0);
    chk("t5_rvalid", rd_valid, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_data", rd_data, 0);
    chk("t5_ferr", frame_err, 0);
    chk("t5_ovr", overrun, 0);
    idle(20);
    send(8'h4B, 1, -1, 0, 0);
    idle(4);
    read_exp(8'h4B);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
